// File: rtl/nes_flash_rd.sv
// Flash read sequencer: turns single-byte PRG/CHR read requests into timed parallel-NOR
// read cycles, with a one-entry last-address cache to skip repeated fetches.
module nes_flash_rd #(
    parameter int unsigned WAIT_CYC = 7,
    parameter int unsigned RST_CYC  = 50,
    parameter int unsigned CACHE_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req,
    input  logic [22:0] i_addr,
    input  logic        i_flush,
    output logic [7:0]  o_rdata,
    output logic        o_ack,
    output logic        o_busy,
    output logic [22:0] o_fl_addr,
    input  logic [7:0]  i_fl_dq,
    output logic        o_fl_ce_n,
    output logic        o_fl_oe_n,
    output logic        o_fl_we_n,
    output logic        o_fl_rst_n
);

    typedef enum logic [2:0] {StInit, StIdle, StSetup, StWait, StDone} state_e;

    localparam logic [7:0] WaitLoad = 8'(WAIT_CYC - 1);
    localparam logic [7:0] RstLast  = 8'(RST_CYC - 1);
    localparam bit         CacheOn  = (CACHE_EN != 0);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [22:0] fl_addr_q, fl_addr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic [22:0] tag_q, tag_d;
    logic [7:0]  data_q, data_d;
    logic        hit;

    assign hit = CacheOn && valid_q && (i_addr == tag_q) && !i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= StInit;
            cnt_q     <= 8'd0;
            fl_addr_q <= 23'd0;
            rdata_q   <= 8'd0;
            valid_q   <= 1'b0;
            tag_q     <= 23'd0;
            data_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fl_addr_q <= fl_addr_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fl_addr_d = fl_addr_q;
        rdata_d   = rdata_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        unique case (state_q)
            StInit: begin
                if (cnt_q == RstLast) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StIdle: begin
                if (i_req) begin
                    fl_addr_d = i_addr;
                    if (hit) begin
                        state_d = StDone;
                        rdata_d = data_q;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                cnt_d   = WaitLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == 8'd0) begin
                    rdata_d = i_fl_dq;
                    if (CacheOn) begin
                        tag_d   = fl_addr_q;
                        data_d  = i_fl_dq;
                        valid_d = 1'b1;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StInit;
        endcase
        // Flush overrides a same-edge fill; the returned data is unaffected.
        if (i_flush) valid_d = 1'b0;
    end

    always_comb begin
        o_ack      = 1'b0;
        o_busy     = 1'b1;
        o_fl_ce_n  = 1'b1;
        o_fl_oe_n  = 1'b1;
        o_fl_rst_n = 1'b1;
        unique case (state_q)
            StInit:  o_fl_rst_n = 1'b0;
            StIdle:  o_busy = 1'b0;
            StSetup, StWait: begin
                o_fl_ce_n = 1'b0;
                o_fl_oe_n = 1'b0;
            end
            StDone:  o_ack = 1'b1;
            default: o_fl_rst_n = 1'b0;
        endcase
    end

    assign o_fl_we_n = 1'b1;
    assign o_fl_addr = fl_addr_q;
    assign o_rdata   = rdata_q;

endmodule
